// File: rtl/sqrt2_sched_pkg.sv
// Shared encodings for the sqrt2 scheduler: FSM states, response flag bit
// positions and the quiet-NaN word returned on a watchdog abort.
package sqrt2_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = S_IDLE,
        SETUP = S_SETUP,
        START = S_START,
        WAIT  = S_WAIT,
        RESP  = S_RESP
    } state_t;

    localparam int FLAG_NAN  = 0;
    localparam int FLAG_PINF = 1;
    localparam int FLAG_NINF = 2;
    localparam int FLAG_TMO  = 3;

    localparam logic [15:0] QNAN = 16'h7E00;

endpackage

// File: rtl/sqrt2_sched_if.sv
// Requester operand channels and the tagged response channel of the scheduler.
// master = requester/consumer side, slave = scheduler side.
interface sqrt2_sched_if #(
    parameter int W = 16
);
    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_data;
    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_data;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_data;
    logic [3:0]   rsp_flags;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_flags
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_flags
    );
endinterface

// File: rtl/sqrt2_sched_rr_arb2.sv
// Two-way round-robin arbiter. The pointer only breaks ties; after any
// accepted grant it moves to the requester that was not served.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       gid
);
    logic ptr;

    always_comb begin
        grant = 2'b00;
        gid   = 1'b0;
        if (valid == 2'b11) begin
            gid   = ptr;
            grant = ptr ? 2'b10 : 2'b01;
        end else if (valid[1]) begin
            gid   = 1'b1;
            grant = 2'b10;
        end else if (valid[0]) begin
            grant = 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (advance) begin
            ptr <= ~gid;
        end
    end
endmodule

// File: rtl/sqrt2_sched.sv
// Round-robin front end for the sqrt2 FP16 square-root unit: sequences the
// shared IO_DATA bus and ENABLE, captures the result, and guards with a watchdog.
//
// state | meaning
// IDLE  | waiting for a requester; READY of the granted port is live
// SETUP | operand driven onto sq_data, enable still low
// START | operand still driven, enable raised
// WAIT  | bus released, watchdog running until sq_result or timeout
// RESP  | response presented until rsp_ready
module sqrt2_sched
    import sqrt2_pkg::*;
#(
    parameter int W       = 16,
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    sqrt2_sched_if.slave bus,
    output logic         busy,
    inout  wire  [W-1:0] sq_data,
    output logic         sq_enable,
    input  logic         sq_result,
    input  logic         sq_is_nan,
    input  logic         sq_is_pinf,
    input  logic         sq_is_ninf
);
    // WAIT lasts exactly TIMEOUT cycles: the abort fires on the last one
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t       state;
    logic [W-1:0] operand;
    logic         cur_id;
    logic [7:0]   cnt;
    logic [1:0]   grant;
    logic         gid;
    logic         take;
    logic         drive_en;
    logic         rsp_valid_q;
    logic         rsp_id_q;
    logic [W-1:0] rsp_data_q;
    logic [3:0]   rsp_flags_q;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .valid   ({bus.req1_valid, bus.req0_valid}),
        .advance (take),
        .grant   (grant),
        .gid     (gid)
    );

    assign take           = (state == IDLE) && !rst && (grant != 2'b00);
    assign bus.req0_ready = take && grant[0];
    assign bus.req1_ready = take && grant[1];
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_flags  = rsp_flags_q;

    // rst releases the bus combinationally, without waiting for the edge
    assign drive_en = (state == SETUP || state == START) && !rst;
    assign sq_data  = drive_en ? operand : {W{1'bz}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            operand     <= '0;
            cur_id      <= 1'b0;
            cnt         <= '0;
            busy        <= 1'b0;
            sq_enable   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (take) begin
                        operand <= gid ? bus.req1_data : bus.req0_data;
                        cur_id  <= gid;
                        busy    <= 1'b1;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    sq_enable <= 1'b1;
                    state     <= START;
                end
                START: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (sq_result) begin
                        rsp_data_q             <= sq_data;
                        rsp_flags_q            <= '0;
                        rsp_flags_q[FLAG_NAN]  <= sq_is_nan;
                        rsp_flags_q[FLAG_PINF] <= sq_is_pinf;
                        rsp_flags_q[FLAG_NINF] <= sq_is_ninf;
                        rsp_id_q               <= cur_id;
                        rsp_valid_q            <= 1'b1;
                        sq_enable              <= 1'b0;
                        state                  <= RESP;
                    end else if (cnt == TMO_LAST) begin
                        rsp_data_q            <= W'(QNAN);
                        rsp_flags_q           <= '0;
                        rsp_flags_q[FLAG_TMO] <= 1'b1;
                        rsp_id_q              <= cur_id;
                        rsp_valid_q           <= 1'b1;
                        sq_enable             <= 1'b0;
                        state                 <= RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sqrt2_sched.sv
// Directed bench for sqrt2_sched with a scripted stand-in for the sqrt2 unit.
// The stand-in parks a sentinel on sq_data whenever the scheduler must not drive it.
module tb_sqrt2_sched;
    import sqrt2_pkg::*;

    localparam logic [15:0] SENT = 16'hA5A5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sqrt2_sched_if #(.W(16)) bus ();

    wire  [15:0] sq_data;
    logic        sq_enable;
    logic        busy;
    logic        sq_result  = 1'b0;
    logic        sq_is_nan  = 1'b0;
    logic        sq_is_pinf = 1'b0;
    logic        sq_is_ninf = 1'b0;
    logic        stub_drive = 1'b0;
    logic        park       = 1'b1;
    logic [15:0] stub_val   = 16'h0000;
    logic        tb_en;
    logic [15:0] tb_val;

    assign tb_en   = stub_drive | park;
    assign tb_val  = stub_drive ? stub_val : SENT;
    assign sq_data = tb_en ? tb_val : 16'hzzzz;

    int n_cmp = 0;
    int n_bad = 0;

    sqrt2_sched #(.W(16), .TIMEOUT(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .busy       (busy),
        .sq_data    (sq_data),
        .sq_enable  (sq_enable),
        .sq_result  (sq_result),
        .sq_is_nan  (sq_is_nan),
        .sq_is_pinf (sq_is_pinf),
        .sq_is_ninf (sq_is_ninf)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Called mid grant cycle; answers lat cycles after WAIT entry and returns mid response cycle.
    task automatic serve(input logic id, input int lat, input logic [15:0] val, input logic [2:0] fl);
        cyc();
        if (id) bus.req1_valid = 1'b0; else bus.req0_valid = 1'b0;
        park = 1'b0;
        cyc();
        cyc();
        park = 1'b1;
        repeat (lat) cyc();
        sq_result = 1'b1; stub_drive = 1'b1; stub_val = val;
        {sq_is_ninf, sq_is_pinf, sq_is_nan} = fl;
        cyc();
        sq_result = 1'b0; stub_drive = 1'b0;
        {sq_is_ninf, sq_is_pinf, sq_is_nan} = 3'b000;
        mid();
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.req0_valid = 1'b1; bus.req0_data = 16'h4400;
        repeat (3) cyc();
        mid();
        n_cmp++; if (bus.req0_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready0: got %b want 0", bus.req0_ready); end
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_id !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_id: got %b want 0", bus.rsp_id); end
        n_cmp++; if (bus.rsp_data !== 16'h0000) begin n_bad++; $display("FAIL reset_rsp_data: got %h want 0000", bus.rsp_data); end
        n_cmp++; if (bus.rsp_flags !== 4'b0000) begin n_bad++; $display("FAIL reset_rsp_flags: got %b want 0000", bus.rsp_flags); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (sq_enable !== 1'b0) begin n_bad++; $display("FAIL reset_enable: got %b want 0", sq_enable); end
        n_cmp++; if (sq_data !== SENT) begin n_bad++; $display("FAIL reset_bus: got %h want %h", sq_data, SENT); end
        cyc();
        rst = 1'b0; bus.req0_valid = 1'b0;
        mid();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_no_grant: busy got %b want 0", busy); end
    endtask

    task automatic test_contention();
        cyc();
        bus.req0_valid = 1'b1; bus.req0_data = 16'h4400;
        bus.req1_valid = 1'b1; bus.req1_data = 16'h4C00;
        mid();
        n_cmp++; if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin n_bad++; $display("FAIL cont_grant0: ready got %b want 01", {bus.req1_ready, bus.req0_ready}); end
        serve(1'b0, 2, 16'h4000, 3'b000);
        n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_bad++; $display("FAIL cont_rsp0_valid: got %b want 1", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_id !== 1'b0) begin n_bad++; $display("FAIL cont_rsp0_id: got %b want 0", bus.rsp_id); end
        n_cmp++; if (bus.rsp_data !== 16'h4000) begin n_bad++; $display("FAIL cont_rsp0_data: got %h want 4000", bus.rsp_data); end
        cyc();
        mid();
        n_cmp++; if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin n_bad++; $display("FAIL cont_grant1: ready got %b want 10", {bus.req1_ready, bus.req0_ready}); end
        serve(1'b1, 0, 16'h4400, 3'b000);
        n_cmp++; if (bus.rsp_id !== 1'b1) begin n_bad++; $display("FAIL cont_rsp1_id: got %b want 1", bus.rsp_id); end
        n_cmp++; if (bus.rsp_data !== 16'h4400) begin n_bad++; $display("FAIL cont_rsp1_data: got %h want 4400", bus.rsp_data); end
        n_cmp++; if (bus.rsp_flags !== 4'b0000) begin n_bad++; $display("FAIL cont_rsp1_flags: got %b want 0000", bus.rsp_flags); end
        cyc();
        mid();
    endtask

    task automatic test_single();
        cyc();
        bus.req0_valid = 1'b1; bus.req0_data = 16'h4400;
        mid();
        n_cmp++; if (bus.req0_ready !== 1'b1) begin n_bad++; $display("FAIL single_ready: got %b want 1", bus.req0_ready); end
        n_cmp++; if (sq_data !== SENT) begin n_bad++; $display("FAIL single_bus_grant: got %h want %h", sq_data, SENT); end
        cyc();
        bus.req0_valid = 1'b0; park = 1'b0;
        mid();
        n_cmp++; if (sq_data !== 16'h4400) begin n_bad++; $display("FAIL single_bus_setup: got %h want 4400", sq_data); end
        n_cmp++; if (sq_enable !== 1'b0) begin n_bad++; $display("FAIL single_en_setup: got %b want 0", sq_enable); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b want 1", busy); end
        cyc();
        mid();
        n_cmp++; if (sq_data !== 16'h4400) begin n_bad++; $display("FAIL single_bus_start: got %h want 4400", sq_data); end
        n_cmp++; if (sq_enable !== 1'b1) begin n_bad++; $display("FAIL single_en_start: got %b want 1", sq_enable); end
        cyc();
        park = 1'b1; sq_result = 1'b1; stub_drive = 1'b1; stub_val = 16'h4000;
        mid();
        n_cmp++; if (sq_data !== 16'h4000) begin n_bad++; $display("FAIL single_bus_wait: got %h want 4000", sq_data); end
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL single_early_rsp: got %b want 0", bus.rsp_valid); end
        cyc();
        sq_result = 1'b0; stub_drive = 1'b0;
        mid();
        n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_bad++; $display("FAIL single_rsp_valid: got %b want 1", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_id !== 1'b0) begin n_bad++; $display("FAIL single_rsp_id: got %b want 0", bus.rsp_id); end
        n_cmp++; if (bus.rsp_data !== 16'h4000) begin n_bad++; $display("FAIL single_rsp_data: got %h want 4000", bus.rsp_data); end
        n_cmp++; if (bus.rsp_flags !== 4'b0000) begin n_bad++; $display("FAIL single_rsp_flags: got %b want 0000", bus.rsp_flags); end
        n_cmp++; if (sq_enable !== 1'b0) begin n_bad++; $display("FAIL single_en_resp: got %b want 0", sq_enable); end
        n_cmp++; if (sq_data !== SENT) begin n_bad++; $display("FAIL single_bus_resp: got %h want %h", sq_data, SENT); end
        cyc();
        mid();
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL single_rsp_drop: got %b want 0", bus.rsp_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_idle: busy got %b want 0", busy); end
    endtask

    task automatic test_repeat_collision();
        cyc();
        bus.req0_valid = 1'b1; bus.req0_data = 16'h4400;
        bus.req1_valid = 1'b1; bus.req1_data = 16'h4C00;
        mid();
        n_cmp++; if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin n_bad++; $display("FAIL rep_grant1: ready got %b want 10", {bus.req1_ready, bus.req0_ready}); end
        serve(1'b1, 1, 16'h4400, 3'b000);
        n_cmp++; if (bus.rsp_id !== 1'b1) begin n_bad++; $display("FAIL rep_rsp1_id: got %b want 1", bus.rsp_id); end
        cyc();
        mid();
        n_cmp++; if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin n_bad++; $display("FAIL rep_grant0: ready got %b want 01", {bus.req1_ready, bus.req0_ready}); end
        serve(1'b0, 0, 16'h4000, 3'b000);
        n_cmp++; if (bus.rsp_id !== 1'b0) begin n_bad++; $display("FAIL rep_rsp0_id: got %b want 0", bus.rsp_id); end
        cyc();
        mid();
    endtask

    task automatic test_special();
        cyc();
        bus.req0_valid = 1'b1; bus.req0_data = 16'hC400;
        mid();
        serve(1'b0, 1, 16'h7E00, 3'b001);
        n_cmp++; if (bus.rsp_flags !== 4'b0001) begin n_bad++; $display("FAIL spec_neg_flags: got %b want 0001", bus.rsp_flags); end
        n_cmp++; if (bus.rsp_data !== 16'h7E00) begin n_bad++; $display("FAIL spec_neg_data: got %h want 7e00", bus.rsp_data); end
        cyc();
        bus.req1_valid = 1'b1; bus.req1_data = 16'h7C00;
        mid();
        serve(1'b1, 1, 16'h7C00, 3'b010);
        n_cmp++; if (bus.rsp_flags !== 4'b0010) begin n_bad++; $display("FAIL spec_pinf_flags: got %b want 0010", bus.rsp_flags); end
        n_cmp++; if (bus.rsp_data !== 16'h7C00) begin n_bad++; $display("FAIL spec_pinf_data: got %h want 7c00", bus.rsp_data); end
        n_cmp++; if (bus.rsp_id !== 1'b1) begin n_bad++; $display("FAIL spec_pinf_id: got %b want 1", bus.rsp_id); end
        cyc();
        mid();
    endtask

    task automatic test_watchdog();
        cyc();
        bus.req0_valid = 1'b1; bus.req0_data = 16'h3C00;
        mid();
        cyc();
        bus.req0_valid = 1'b0;
        repeat (9) cyc();
        mid();
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL wd_early: rsp_valid got %b want 0", bus.rsp_valid); end
        n_cmp++; if (sq_enable !== 1'b1) begin n_bad++; $display("FAIL wd_en_wait: got %b want 1", sq_enable); end
        cyc();
        mid();
        n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_bad++; $display("FAIL wd_rsp_valid: got %b want 1", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_data !== 16'h7E00) begin n_bad++; $display("FAIL wd_rsp_data: got %h want 7e00", bus.rsp_data); end
        n_cmp++; if (bus.rsp_flags !== 4'b1000) begin n_bad++; $display("FAIL wd_rsp_flags: got %b want 1000", bus.rsp_flags); end
        n_cmp++; if (sq_enable !== 1'b0) begin n_bad++; $display("FAIL wd_en_resp: got %b want 0", sq_enable); end
        cyc();
        mid();
    endtask

    task automatic test_watchdog_edge();
        cyc();
        bus.req1_valid = 1'b1; bus.req1_data = 16'h4400;
        mid();
        serve(1'b1, 7, 16'h4000, 3'b000);
        n_cmp++; if (bus.rsp_flags !== 4'b0000) begin n_bad++; $display("FAIL wd_edge_flags: got %b want 0000", bus.rsp_flags); end
        n_cmp++; if (bus.rsp_data !== 16'h4000) begin n_bad++; $display("FAIL wd_edge_data: got %h want 4000", bus.rsp_data); end
        cyc();
        mid();
    endtask

    task automatic test_backpressure();
        bus.rsp_ready = 1'b0;
        cyc();
        bus.req0_valid = 1'b1; bus.req0_data = 16'h4400;
        bus.req1_valid = 1'b1; bus.req1_data = 16'h4C00;
        mid();
        serve(1'b0, 0, 16'h4000, 3'b000);
        bus.req0_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            sq_result = (i == 2); stub_drive = (i == 2); stub_val = 16'h1234;
            mid();
            n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid[%0d]: got %b want 1", i, bus.rsp_valid); end
            n_cmp++; if ({bus.rsp_id, bus.rsp_data} !== {1'b0, 16'h4000}) begin n_bad++; $display("FAIL bp_hold[%0d]: got %b/%h want 0/4000", i, bus.rsp_id, bus.rsp_data); end
            n_cmp++; if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin n_bad++; $display("FAIL bp_ready[%0d]: got %b want 00", i, {bus.req1_ready, bus.req0_ready}); end
        end
        cyc();
        sq_result = 1'b0; stub_drive = 1'b0; bus.rsp_ready = 1'b1;
        mid();
        n_cmp++; if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin n_bad++; $display("FAIL bp_hs_ready: got %b want 00", {bus.req1_ready, bus.req0_ready}); end
        cyc();
        mid();
        n_cmp++; if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin n_bad++; $display("FAIL bp_next_grant: got %b want 10", {bus.req1_ready, bus.req0_ready}); end
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_rsp_drop: got %b want 0", bus.rsp_valid); end
        serve(1'b1, 0, 16'h4400, 3'b000);
        cyc();
        mid();
        serve(1'b0, 0, 16'h4000, 3'b000);
        n_cmp++; if (bus.rsp_id !== 1'b0) begin n_bad++; $display("FAIL bp_last_id: got %b want 0", bus.rsp_id); end
        cyc();
        mid();
    endtask

    task automatic test_reset_mid_wait();
        cyc();
        bus.req0_valid = 1'b1; bus.req0_data = 16'h4400;
        mid();
        cyc();
        bus.req0_valid = 1'b0;
        repeat (3) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        mid();
        n_cmp++; if (sq_enable !== 1'b0) begin n_bad++; $display("FAIL rst_enable: got %b want 0", sq_enable); end
        n_cmp++; if (sq_data !== SENT) begin n_bad++; $display("FAIL rst_bus: got %h want %h", sq_data, SENT); end
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid: got %b want 0", bus.rsp_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        cyc();
        sq_result = 1'b1; stub_drive = 1'b1; stub_val = 16'h4000;
        cyc();
        sq_result = 1'b0; stub_drive = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mid();
            n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_stray_rsp[%0d]: got %b want 0", i, bus.rsp_valid); end
            cyc();
        end
        bus.req0_valid = 1'b1; bus.req0_data = 16'h4400;
        bus.req1_valid = 1'b1; bus.req1_data = 16'h4C00;
        mid();
        n_cmp++; if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin n_bad++; $display("FAIL rst_ptr: ready got %b want 01", {bus.req1_ready, bus.req0_ready}); end
        serve(1'b0, 0, 16'h4000, 3'b000);
        n_cmp++; if (bus.rsp_data !== 16'h4000) begin n_bad++; $display("FAIL rst_after_data: got %h want 4000", bus.rsp_data); end
        bus.req1_valid = 1'b0;
        cyc();
        mid();
    endtask

    initial begin
        bus.req0_valid = 1'b0; bus.req0_data = 16'h0000;
        bus.req1_valid = 1'b0; bus.req1_data = 16'h0000;
        bus.rsp_ready  = 1'b1;
        test_reset();
        test_contention();
        test_single();
        test_repeat_collision();
        test_special();
        test_watchdog();
        test_watchdog_edge();
        test_backpressure();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at 200000");
        $fatal(1);
    end
endmodule
